// File: rtl/sysid_checker_pkg.sv
// Shared definitions for the system-ID checker: FSM states, word addresses
// and the default expected values emitted by the system-ID generator script.
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_LAT     = 2'd2,
    ST_COMPARE = 2'd3
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1489442558;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the system-ID
// slave. Handshake: the master holds avm_read and avm_address stable while
// avm_waitrequest is high; the read is accepted in the cycle where avm_read=1
// and avm_waitrequest=0. Read data is valid in the accept cycle for a
// zero-latency slave, otherwise exactly READ_LATENCY cycles after accept.
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_checker.sv
// Reads the system-ID slave's ID and timestamp words on request (or
// periodically) and flags whether they match the build-time values.
// All outputs come straight from flops.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          RECHECK_PERIOD     = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  sysid_checker_if.master avm,
  output logic [31:0]    id_value,
  output logic [31:0]    timestamp_value,
  output logic           busy,
  output logic           done,
  output logic           id_match,
  output logic           ts_match,
  output logic           timeout,
  output state_e         dbg_state
);

  // Terminal counts; the latency one is unused when READ_LATENCY is 0.
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);
  localparam logic [31:0] RC_LAST  = 32'(RECHECK_PERIOD - 1);

  state_e      state_q;
  logic        addr_sel_q;
  logic        avm_read_q;
  logic        avm_address_q;
  logic [31:0] id_value_q;
  logic [31:0] ts_value_q;
  logic        busy_q;
  logic        done_q;
  logic        id_match_q;
  logic        ts_match_q;
  logic        timeout_q;
  logic        armed_q;
  logic [15:0] to_cnt_q;
  logic [1:0]  lat_q;
  logic [31:0] rc_q;

  logic        recheck_fire;
  logic        kick;

  // Periodic re-check becomes possible only once a check has completed.
  // rc_q is reloaded to 1 while busy, so it equals the IDLE cycle number and
  // the next read starts RECHECK_PERIOD cycles after the done pulse.
  assign recheck_fire = (RECHECK_PERIOD != 0) && armed_q && (rc_q >= RC_LAST);
  assign kick         = start || recheck_fire;

  // Single FSM: sequences the two reads, counts stalls/latency/recheck and
  // registers every output. Flags and done are loaded on entry to COMPARE so
  // the done pulse and the match flags are visible during the COMPARE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_sel_q    <= SYSID_ADDR_ID;
      avm_read_q    <= 1'b0;
      avm_address_q <= SYSID_ADDR_ID;
      id_value_q    <= 32'd0;
      ts_value_q    <= 32'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      timeout_q     <= 1'b0;
      armed_q       <= 1'b0;
      to_cnt_q      <= 16'd0;
      lat_q         <= 2'd0;
      rc_q          <= 32'd0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE) begin
        rc_q <= 32'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (kick) begin
            state_q       <= ST_READ;
            addr_sel_q    <= SYSID_ADDR_ID;
            avm_read_q    <= 1'b1;
            avm_address_q <= SYSID_ADDR_ID;
            busy_q        <= 1'b1;
            timeout_q     <= 1'b0;
            id_match_q    <= 1'b0;
            ts_match_q    <= 1'b0;
            to_cnt_q      <= 16'd0;
          end else if ((RECHECK_PERIOD != 0) && armed_q) begin
            rc_q <= rc_q + 32'd1;
          end
        end

        ST_READ: begin
          if (!avm.avm_waitrequest) begin
            to_cnt_q <= 16'd0;
            if (READ_LATENCY == 0) begin
              if (addr_sel_q == SYSID_ADDR_ID) begin
                id_value_q    <= avm.avm_readdata;
                addr_sel_q    <= SYSID_ADDR_TS;
                avm_address_q <= SYSID_ADDR_TS;
              end else begin
                ts_value_q <= avm.avm_readdata;
                avm_read_q <= 1'b0;
                id_match_q <= (id_value_q == EXPECTED_ID);
                ts_match_q <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
                done_q     <= 1'b1;
                armed_q    <= 1'b1;
                state_q    <= ST_COMPARE;
              end
            end else begin
              avm_read_q <= 1'b0;
              lat_q      <= 2'd0;
              state_q    <= ST_LAT;
            end
          end else if (to_cnt_q == TO_LAST) begin
            // Abort: flags were already cleared when the check started.
            to_cnt_q   <= 16'd0;
            avm_read_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end

        ST_LAT: begin
          if (lat_q == LAT_LAST) begin
            if (addr_sel_q == SYSID_ADDR_ID) begin
              id_value_q    <= avm.avm_readdata;
              addr_sel_q    <= SYSID_ADDR_TS;
              avm_address_q <= SYSID_ADDR_TS;
              avm_read_q    <= 1'b1;
              state_q       <= ST_READ;
            end else begin
              ts_value_q <= avm.avm_readdata;
              id_match_q <= (id_value_q == EXPECTED_ID);
              ts_match_q <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
              done_q     <= 1'b1;
              armed_q    <= 1'b1;
              state_q    <= ST_COMPARE;
            end
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end

        ST_COMPARE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign avm.avm_read    = avm_read_q;
  assign avm.avm_address = avm_address_q;
  assign id_value        = id_value_q;
  assign timestamp_value = ts_value_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_match        = id_match_q;
  assign ts_match        = ts_match_q;
  assign timeout         = timeout_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: three instances cover zero latency with
// an 8-cycle timeout, two-cycle read latency, and a 20-cycle re-check.
module tb_sysid_checker;
  import sysid_checker_pkg::*;

  localparam logic [31:0] EXP_TS = 32'd1489442558;
  localparam logic [31:0] ID1    = 32'hA5A50001;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT 0: latency 0, timeout 8, no recheck
  sysid_checker_if if0();
  logic        start0, wait0;
  logic [31:0] id_word0, ts_word0;
  logic [31:0] idv0, tsv0;
  logic        busy0, done0, idm0, tsm0, to0;
  state_e      st0;
  assign if0.avm_waitrequest = wait0;
  assign if0.avm_readdata    = if0.avm_address ? ts_word0 : id_word0;

  sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(8), .RECHECK_PERIOD(0)) u0 (
    .clock(clk), .reset(rst), .start(start0), .avm(if0.master),
    .id_value(idv0), .timestamp_value(tsv0), .busy(busy0), .done(done0),
    .id_match(idm0), .ts_match(tsm0), .timeout(to0), .dbg_state(st0)
  );

  // DUT 1: latency 2, non-default expected ID
  sysid_checker_if if1();
  logic        start1, wait1;
  logic [31:0] idv1, tsv1;
  logic        busy1, done1, idm1, tsm1, to1;
  state_e      st1;
  logic [1:0]  p_v, p_a;
  // slave model: data valid only in the second cycle after accept
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_v <= 2'b00;
      p_a <= 2'b00;
    end else begin
      p_v <= {p_v[0], if1.avm_read & ~if1.avm_waitrequest};
      p_a <= {p_a[0], if1.avm_address};
    end
  end
  assign if1.avm_waitrequest = wait1;
  assign if1.avm_readdata    = p_v[1] ? (p_a[1] ? EXP_TS : ID1) : 32'hDEADBEEF;

  sysid_checker #(.EXPECTED_ID(ID1), .READ_LATENCY(2)) u1 (
    .clock(clk), .reset(rst), .start(start1), .avm(if1.master),
    .id_value(idv1), .timestamp_value(tsv1), .busy(busy1), .done(done1),
    .id_match(idm1), .ts_match(tsm1), .timeout(to1), .dbg_state(st1)
  );

  // DUT 2: recheck every 20 cycles
  sysid_checker_if if2();
  logic        start2;
  logic [31:0] idv2, tsv2;
  logic        busy2, done2, idm2, tsm2, to2;
  state_e      st2;
  assign if2.avm_waitrequest = 1'b0;
  assign if2.avm_readdata    = if2.avm_address ? EXP_TS : 32'd0;

  sysid_checker #(.RECHECK_PERIOD(20)) u2 (
    .clock(clk), .reset(rst), .start(start2), .avm(if2.master),
    .id_value(idv2), .timestamp_value(tsv2), .busy(busy2), .done(done2),
    .id_match(idm2), .ts_match(tsm2), .timeout(to2), .dbg_state(st2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    wait0 = 1'b0; wait1 = 1'b0;
    id_word0 = 32'd0; ts_word0 = EXP_TS;
    repeat (3) step();

    // reset state
    check("rst_read", 32'(if0.avm_read), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_flags", {29'd0, idm0, tsm0, to0}, 32'd0);
    check("rst_idv", idv0, 32'd0);
    check("rst_tsv", tsv0, 32'd0);
    check("rst_state", 32'(st0), 32'(ST_IDLE));
    rst = 1'b0;
    step();

    // T1: matching words, no wait
    start0 = 1'b1; step(); start0 = 1'b0;             // cycle 1
    check("t1_c1_read", 32'(if0.avm_read), 32'd1);
    check("t1_c1_addr", 32'(if0.avm_address), 32'd0);
    check("t1_c1_busy", 32'(busy0), 32'd1);
    step();                                            // cycle 2
    check("t1_c2_read", 32'(if0.avm_read), 32'd1);
    check("t1_c2_addr", 32'(if0.avm_address), 32'd1);
    check("t1_c2_done", 32'(done0), 32'd0);
    step();                                            // cycle 3
    check("t1_c3_done", 32'(done0), 32'd1);
    check("t1_c3_flags", {29'd0, idm0, tsm0, to0}, 32'b110);
    check("t1_c3_tsv", tsv0, EXP_TS);
    check("t1_c3_read", 32'(if0.avm_read), 32'd0);
    step();                                            // cycle 4
    check("t1_c4_done", 32'(done0), 32'd0);
    check("t1_c4_busy", 32'(busy0), 32'd0);

    // T2: timestamp mismatch
    ts_word0 = 32'h12345678;
    start0 = 1'b1; step(); start0 = 1'b0;
    step(); step();                                    // cycle 3
    check("t2_done", 32'(done0), 32'd1);
    check("t2_flags", {29'd0, idm0, tsm0, to0}, 32'b100);
    check("t2_tsv", tsv0, 32'h12345678);
    step();

    // T3: ID mismatch
    id_word0 = 32'hCAFE0001; ts_word0 = EXP_TS;
    start0 = 1'b1; step(); start0 = 1'b0;
    step(); step();
    check("t3_done", 32'(done0), 32'd1);
    check("t3_flags", {29'd0, idm0, tsm0, to0}, 32'b010);
    check("t3_idv", idv0, 32'hCAFE0001);
    step();

    // T4: waitrequest stuck high, timeout 8
    wait0 = 1'b1;
    start0 = 1'b1; step(); start0 = 1'b0;             // cycle 1
    check("t4_c1_read", 32'(if0.avm_read), 32'd1);
    repeat (7) step();                                 // cycle 8
    check("t4_c8_done", 32'(done0), 32'd0);
    check("t4_c8_read", 32'(if0.avm_read), 32'd1);
    step();                                            // cycle 9
    check("t4_c9_done", 32'(done0), 32'd1);
    check("t4_c9_flags", {29'd0, idm0, tsm0, to0}, 32'b001);
    check("t4_c9_read", 32'(if0.avm_read), 32'd0);
    check("t4_c9_idv_held", idv0, 32'hCAFE0001);
    step();                                            // cycle 10
    check("t4_c10_done", 32'(done0), 32'd0);
    check("t4_c10_to", 32'(to0), 32'd1);
    check("t4_c10_busy", 32'(busy0), 32'd0);

    // T5: start held while busy is ignored
    wait0 = 1'b0; id_word0 = 32'd0;
    start0 = 1'b1; step();                             // cycle 1
    step(); step();                                    // cycle 3
    check("t5_c3_done", 32'(done0), 32'd1);
    check("t5_c3_flags", {29'd0, idm0, tsm0, to0}, 32'b110);
    start0 = 1'b0;
    step();                                            // cycle 4
    check("t5_c4_read", 32'(if0.avm_read), 32'd0);
    check("t5_c4_busy", 32'(busy0), 32'd0);
    step();
    check("t5_c5_read", 32'(if0.avm_read), 32'd0);

    // T6: reset mid-read
    wait0 = 1'b1;
    start0 = 1'b1; step(); start0 = 1'b0;
    step();
    check("t6_pre_read", 32'(if0.avm_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_read", 32'(if0.avm_read), 32'd0);
    check("t6_rst_busy", 32'(busy0), 32'd0);
    check("t6_rst_tsv", tsv0, 32'd0);
    check("t6_rst_flags", {29'd0, idm0, tsm0, to0}, 32'd0);
    check("t6_rst_state", 32'(st0), 32'(ST_IDLE));
    step();
    rst = 1'b0; wait0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_quiet_done", 32'(done0), 32'd0);
      check("t6_quiet_read", 32'(if0.avm_read), 32'd0);
    end
    start0 = 1'b1; step(); start0 = 1'b0;
    step(); step();
    check("t6_restart_done", 32'(done0), 32'd1);
    check("t6_restart_tsv", tsv0, EXP_TS);
    step();

    // T7: two stall cycles then READ_LATENCY=2
    wait1 = 1'b1;
    start1 = 1'b1; step(); start1 = 1'b0;             // cycle 1
    check("t7_c1_read", 32'(if1.avm_read), 32'd1);
    step();                                            // cycle 2
    check("t7_c2_read", 32'(if1.avm_read), 32'd1);
    step(); wait1 = 1'b0;                              // cycle 3
    check("t7_c3_read", 32'(if1.avm_read), 32'd1);
    step();                                            // cycle 4
    check("t7_c4_read", 32'(if1.avm_read), 32'd0);
    step();                                            // cycle 5
    check("t7_c5_read", 32'(if1.avm_read), 32'd0);
    step();                                            // cycle 6
    check("t7_c6_read", 32'(if1.avm_read), 32'd1);
    check("t7_c6_addr", 32'(if1.avm_address), 32'd1);
    check("t7_c6_idv", idv1, ID1);
    step(); step();                                    // cycle 8
    check("t7_c8_done", 32'(done1), 32'd0);
    step();                                            // cycle 9
    check("t7_c9_done", 32'(done1), 32'd1);
    check("t7_c9_flags", {29'd0, idm1, tsm1, to1}, 32'b110);
    check("t7_c9_tsv", tsv1, EXP_TS);
    step();
    check("t7_c10_done", 32'(done1), 32'd0);

    // T8: automatic recheck 20 cycles after done
    start2 = 1'b1; step(); start2 = 1'b0;             // cycle 1
    step(); step();                                    // cycle 3
    check("t8_done1", 32'(done2), 32'd1);
    for (int c = 4; c <= 22; c++) begin
      step();
      check("t8_idle_read", 32'(if2.avm_read), 32'd0);
    end
    step();                                            // cycle 23
    check("t8_recheck_read", 32'(if2.avm_read), 32'd1);
    check("t8_recheck_addr", 32'(if2.avm_address), 32'd0);
    step(); step();                                    // cycle 25
    check("t8_done2", 32'(done2), 32'd1);
    check("t8_flags2", {29'd0, idm2, tsm2, to2}, 32'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
